ctr_retire_sync: RTL and testbench
==================================

# ctr_retire_sync

Lockstep retirement synchronizer for the two-copy contract-checking harness. Each CPU copy retires instructions at its own pace. This block buffers each copy's retirement observations and releases them pairwise to the contract checker as a single `retire_o` pulse with both observation sets aligned. It back-pressures the copy that runs ahead and flags a desynchronization when one copy stops retiring.

## Interface
Parameters:
- `DEPTH`, 4: entries per copy FIFO; power of two, ≥2.
- `TIMEOUT`, 64: cycles one side may wait alone before desync; ≥1.
- `CNT_W`, 32: width of the pair counter.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `valid_1_i`, `valid_2_i`  in  1  copy retires an instruction this cycle.
- `obs_1_i`, `obs_2_i`  in  `ctr_pkg::obs_t`  retirement observation: `instr`, `reg_rs1`, `reg_rs2`, `reg_rd`, `mem_addr`, `mem_r_data`, `mem_w_data`, each 32 b.
- `stall_1_o`, `stall_2_o`  out  1  copy must hold retirement next cycle.
- `retire_o`  out  1  one-cycle pulse; paired observation valid.
- `obs_1_o`, `obs_2_o`  out  `obs_t`  registered paired observations, held between pulses.
- `pair_cnt_o`  out  `CNT_W`  pairs released since reset; wraps modulo 2^`CNT_W`.
- `overflow_o`  out  1  sticky; an entry was dropped.
- `desync_o`  out  1  sticky; timeout expired.

## Operation
- Each copy has a private FIFO (`ctr_obs_fifo`).
- Push condition: `valid_x_i` and either not full, or full with a pop in the same cycle. Push and pop in the same cycle are both legal.
- Pop condition: FSM in RUN, and both FIFOs non-empty. Both FIFOs always pop together.
- On pop:
  - `obs_1_o`/`obs_2_o` load the two heads.
  - `retire_o` is 1 in the next cycle.
  - `pair_cnt_o` increments.
- Drop condition: `valid_x_i` while the FIFO is full and there is no pop.
  - The entry is discarded and `overflow_o` sets to 1.
  - The other side is unaffected.
- `stall_x_o` is combinational and equals 1 when that FIFO holds ≥ `DEPTH-1` entries. This gives one entry of slack for a one-cycle producer response.
- Wait counter (`$clog2(TIMEOUT+1)` b):
  - Increments in cycles where exactly one FIFO is non-empty.
  - Clears when both FIFOs are empty or both are non-empty.
- FSM, two states:
  - RUN → DESYNC when the wait counter equals `TIMEOUT`.
  - DESYNC is terminal until `rst_i`. In DESYNC: no pops, `retire_o`=0, `desync_o`=1, both `stall_x_o`=1. Pushes continue until the FIFOs are full; overflow is still recorded.
- The FIFO is a circular buffer:
  - Pointers are `$clog2(DEPTH)+1` b; full/empty is decided by the MSB comparison.
  - Wrap-around at `DEPTH` is required.

## Timing
- Reset values:
  - `retire_o`=0, `obs_*_o`=0, `pair_cnt_o`=0.
  - `overflow_o`=0, `desync_o`=0.
  - FIFOs empty, wait counter 0, FSM=RUN.
  - `stall_*_o`=0, since they follow FIFO counts.
- `rst_i` asserted mid-operation discards all buffered entries at that edge. Inputs in the reset cycle are ignored.
- Latency: both copies pushing into empty FIFOs at edge k gives `retire_o`=1 in the cycle after edge k+1. There is no same-cycle bypass.
- Throughput: one pair per cycle when both copies retire every cycle.
- `obs_*_o` are stable whenever `retire_o`=1. Downstream may sample them at the falling edge.
- Desync: `desync_o` rises the cycle after the wait counter reaches `TIMEOUT`. A pop in the same cycle as the counter reaching `TIMEOUT` is impossible, because one side is empty.

## Structure
- `ctr_pkg`:
  - `obs_t` packed struct (7×32 b).
  - `sync_state_e` enum (`RUN`, `DESYNC`).
  - Width constant `OBS_W`=224.
- `ctr_obs_fifo`:
  - Parameterized by `DEPTH` and type `obs_t`.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `empty`, `full`, `count`.
  - Instantiated twice.
- The top level holds the pop logic, output registers, pair counter, wait counter, FSM and sticky flags.

## Test plan
- Both copies retire together; `instr` values 0x00000013, 0x00500093, 0x00a00113 over 3 cycles → three consecutive `retire_o` pulses starting 2 cycles after the first valid; `obs_1_o.instr` == `obs_2_o.instr` in order; `pair_cnt_o`=3.
- Copy 1 retires 3 entries, then copy 2 retires 3 entries 10 cycles later (`DEPTH`=4) → `stall_1_o`=1 after the 3rd push; 3 pulses pair the entries in FIFO order; no `overflow_o`.
- Copy 1 keeps `valid_1_i`=1 for 6 cycles while copy 2 is idle → 4 entries stored, `overflow_o`=1 from the 5th push, later pairs use the first 4 entries.
- Copy 2 never retires after copy 1's single push, `TIMEOUT`=64 → `desync_o`=1 after 64 waiting cycles; no `retire_o` afterwards, even if copy 2 then retires.
- Run 10 pairs, assert `rst_i` for 1 cycle with entries pending → all outputs 0, FIFOs empty, `pair_cnt_o`=0; the next aligned pair retires normally.
- Sustained 2·`DEPTH`+3 aligned retirements with simultaneous push/pop at full → no stall deadlock, no overflow, correct order across pointer wrap.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared types for the two-copy contract-checking harness: retirement observation record
// and the retirement synchronizer state.
package ctr_pkg;

   localparam int unsigned OBS_W = 224;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] reg_rs1;
      logic [31:0] reg_rs2;
      logic [31:0] reg_rd;
      logic [31:0] mem_addr;
      logic [31:0] mem_r_data;
      logic [31:0] mem_w_data;
   } obs_t;

   typedef enum logic {
      RUN,
      DESYNC
   } sync_state_e;

endpackage

// File: rtl/ctr_obs_fifo.sv
// Circular-buffer FIFO holding one copy's retirement observations; extra pointer MSB
// distinguishes full from empty.
module ctr_obs_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         obs_t = ctr_pkg::obs_t
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  logic                     pop,
   input  obs_t                     wdata,
   output obs_t                     rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   obs_t        mem_q [DEPTH];
   logic [AW:0] wptr_q;
   logic [AW:0] rptr_q;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign count = wptr_q - rptr_q;
   assign rdata = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset; stale slots are never visible while the pointers say empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ctr_retire_sync.sv
// Lockstep retirement synchronizer: buffers each copy's retirements and releases them
// pairwise, back-pressuring the leader and flagging a desync when one side goes quiet.
module ctr_retire_sync
   import ctr_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_1_i,
   input  logic             valid_2_i,
   input  obs_t             obs_1_i,
   input  obs_t             obs_2_i,
   output logic             stall_1_o,
   output logic             stall_2_o,
   output logic             retire_o,
   output obs_t             obs_1_o,
   output obs_t             obs_2_o,
   output logic [CNT_W-1:0] pair_cnt_o,
   output logic             overflow_o,
   output logic             desync_o
);

   localparam int unsigned PW     = $clog2(DEPTH) + 1;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   logic          push_1, push_2, pop, drop_1, drop_2;
   logic          empty_1, empty_2, full_1, full_2;
   logic [PW-1:0] count_1, count_2;
   obs_t          head_1, head_2;

   sync_state_e       state_q;
   logic [WAIT_W-1:0] wait_q;
   logic              retire_q, overflow_q;
   obs_t              obs_1_q, obs_2_q;
   logic [CNT_W-1:0]  pair_cnt_q;

   assign pop    = (state_q == RUN) && !empty_1 && !empty_2;
   // A full FIFO still accepts a push when it pops in the same cycle.
   assign push_1 = valid_1_i && (!full_1 || pop);
   assign push_2 = valid_2_i && (!full_2 || pop);
   assign drop_1 = valid_1_i && full_1 && !pop;
   assign drop_2 = valid_2_i && full_2 && !pop;

   assign stall_1_o = (state_q == DESYNC) || (count_1 >= PW'(DEPTH - 1));
   assign stall_2_o = (state_q == DESYNC) || (count_2 >= PW'(DEPTH - 1));

   ctr_obs_fifo #(
      .DEPTH (DEPTH),
      .obs_t (obs_t)
   ) u_fifo_1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push_1),
      .pop   (pop),
      .wdata (obs_1_i),
      .rdata (head_1),
      .empty (empty_1),
      .full  (full_1),
      .count (count_1)
   );

   ctr_obs_fifo #(
      .DEPTH (DEPTH),
      .obs_t (obs_t)
   ) u_fifo_2 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push_2),
      .pop   (pop),
      .wdata (obs_2_i),
      .rdata (head_2),
      .empty (empty_2),
      .full  (full_2),
      .count (count_2)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         wait_q     <= '0;
         retire_q   <= 1'b0;
         overflow_q <= 1'b0;
         obs_1_q    <= '0;
         obs_2_q    <= '0;
         pair_cnt_q <= '0;
      end else begin
         retire_q <= pop;
         if (pop) begin
            obs_1_q    <= head_1;
            obs_2_q    <= head_2;
            pair_cnt_q <= pair_cnt_q + CNT_W'(1);
         end
         if (drop_1 || drop_2) overflow_q <= 1'b1;
         // Counts only while exactly one side has something waiting.
         if (empty_1 == empty_2)                wait_q <= '0;
         else if (wait_q != WAIT_W'(TIMEOUT))   wait_q <= wait_q + WAIT_W'(1);
         if (state_q == RUN && wait_q == WAIT_W'(TIMEOUT)) state_q <= DESYNC;
      end
   end

   assign retire_o   = retire_q;
   assign obs_1_o    = obs_1_q;
   assign obs_2_o    = obs_2_q;
   assign pair_cnt_o = pair_cnt_q;
   assign overflow_o = overflow_q;
   assign desync_o   = (state_q == DESYNC);

endmodule

// File: tb/tb_ctr_retire_sync.sv
// Bench for ctr_retire_sync: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations and a randomized phase.
module tb_ctr_retire_sync;
   import ctr_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned CNT_W   = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             valid_1 = 1'b0, valid_2 = 1'b0;
   obs_t             obs_1_in = '0, obs_2_in = '0;
   logic             stall_1, stall_2, retire, overflow, desync;
   obs_t             obs_1_out, obs_2_out;
   logic [CNT_W-1:0] pair_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model state
   obs_t             q1[$];
   obs_t             q2[$];
   bit               m_retire, m_ovf, m_desync;
   obs_t             m_obs1, m_obs2;
   logic [CNT_W-1:0] m_cnt;
   int               m_lonely;

   always #5 clk = ~clk;

   ctr_retire_sync #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_1_i  (valid_1),
      .valid_2_i  (valid_2),
      .obs_1_i    (obs_1_in),
      .obs_2_i    (obs_2_in),
      .stall_1_o  (stall_1),
      .stall_2_o  (stall_2),
      .retire_o   (retire),
      .obs_1_o    (obs_1_out),
      .obs_2_o    (obs_2_out),
      .pair_cnt_o (pair_cnt),
      .overflow_o (overflow),
      .desync_o   (desync)
   );

   function automatic bit exp_stall(input int size);
      return m_desync || (size >= int'(DEPTH) - 1);
   endfunction

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("retire", 256'(retire), 256'(m_retire));
         chk("obs_1", 256'(obs_1_out), 256'(m_obs1));
         chk("obs_2", 256'(obs_2_out), 256'(m_obs2));
         chk("pair_cnt", 256'(pair_cnt), 256'(m_cnt));
         chk("overflow", 256'(overflow), 256'(m_ovf));
         chk("desync", 256'(desync), 256'(m_desync));
         chk("stall_1", 256'(stall_1), 256'(exp_stall(q1.size())));
         chk("stall_2", 256'(stall_2), 256'(exp_stall(q2.size())));
      end
   end

   task automatic model_update();
      bit pop, alone, nd;
      if (rst) begin
         q1.delete();
         q2.delete();
         m_retire = 0; m_ovf = 0; m_desync = 0;
         m_obs1 = '0; m_obs2 = '0; m_cnt = '0; m_lonely = 0;
      end else begin
         pop   = !m_desync && q1.size() != 0 && q2.size() != 0;
         alone = (q1.size() != 0) != (q2.size() != 0);
         nd    = m_desync || (m_lonely >= int'(TIMEOUT));
         m_retire = pop;
         if (pop) begin
            m_obs1 = q1.pop_front();
            m_obs2 = q2.pop_front();
            m_cnt  = m_cnt + 1;
         end
         if (valid_1) begin
            if (q1.size() < int'(DEPTH)) q1.push_back(obs_1_in);
            else m_ovf = 1;
         end
         if (valid_2) begin
            if (q2.size() < int'(DEPTH)) q2.push_back(obs_2_in);
            else m_ovf = 1;
         end
         m_lonely = alone ? m_lonely + 1 : 0;
         m_desync = nd;
      end
   endtask

   function automatic obs_t mk(input logic [31:0] instr);
      obs_t o;
      o.instr      = instr;
      o.reg_rs1    = $urandom;
      o.reg_rs2    = $urandom;
      o.reg_rd     = $urandom;
      o.mem_addr   = $urandom;
      o.mem_r_data = $urandom;
      o.mem_w_data = $urandom;
      return o;
   endfunction

   task automatic step(input bit r, input bit v1, input obs_t o1, input bit v2, input obs_t o2);
      rst      = r;
      valid_1  = v1;
      obs_1_in = o1;
      valid_2  = v2;
      obs_2_in = o2;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
   endtask

   task automatic do_reset();
      step(1, 0, '0, 0, '0);
      chk_en = 1'b1;
   endtask

   initial begin
      int p1, p2;
      bit v1, v2, r;

      do_reset();
      chk("reset_retire", 256'(retire), 256'(0));
      chk("reset_cnt", 256'(pair_cnt), 256'(0));
      chk("reset_stall", 256'({stall_1, stall_2}), 256'(0));

      // Aligned retirement, two-cycle latency
      step(0, 1, mk(32'h0000_0013), 1, mk(32'h0000_0013));
      chk("t1_no_bypass", 256'(retire), 256'(0));
      step(0, 1, mk(32'h0050_0093), 1, mk(32'h0050_0093));
      chk("t1_first_pulse", 256'(retire), 256'(1));
      chk("t1_instr0", 256'({obs_1_out.instr, obs_2_out.instr}), 256'(64'h13_0000_0013));
      step(0, 1, mk(32'h00a0_0113), 1, mk(32'h00a0_0113));
      chk("t1_instr1", 256'(obs_1_out.instr), 256'(32'h0050_0093));
      idle(1);
      chk("t1_instr2", 256'(obs_2_out.instr), 256'(32'h00a0_0113));
      chk("t1_cnt", 256'(pair_cnt), 256'(3));
      idle(1);
      chk("t1_pulse_end", 256'(retire), 256'(0));

      // Copy 1 leads by 10 cycles
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 1, mk(32'h100 + i), 0, '0);
      chk("t2_stall_1", 256'(stall_1), 256'(1));
      idle(10);
      for (int i = 0; i < 3; i++) step(0, 0, '0, 1, mk(32'h200 + i));
      idle(3);
      chk("t2_cnt", 256'(pair_cnt), 256'(3));
      chk("t2_no_ovf", 256'(overflow), 256'(0));

      // Overflow from the fifth push while copy 2 idles
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(0, 1, mk(32'(i + 1)), 0, '0);
         if (i == 3) chk("t3_no_ovf_yet", 256'(overflow), 256'(0));
         if (i == 4) chk("t3_ovf", 256'(overflow), 256'(1));
      end
      for (int i = 0; i < 4; i++) step(0, 0, '0, 1, mk(32'h300 + i));
      idle(3);
      chk("t3_cnt", 256'(pair_cnt), 256'(4));
      chk("t3_last_instr", 256'(obs_1_out.instr), 256'(4));

      // Desync after TIMEOUT lonely cycles
      do_reset();
      step(0, 1, mk(32'h400), 0, '0);
      idle(64);
      chk("t4_not_yet", 256'(desync), 256'(0));
      idle(1);
      chk("t4_desync", 256'(desync), 256'(1));
      step(0, 0, '0, 1, mk(32'h401));
      idle(3);
      chk("t4_no_retire", 256'({retire, pair_cnt}), 256'(0));

      // Mid-operation reset with entries pending
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 1, mk(32'h500 + i), 1, mk(32'h500 + i));
      step(0, 1, mk(32'h5a0), 0, '0);
      step(0, 1, mk(32'h5a1), 0, '0);
      step(1, 1, mk(32'h5ff), 1, mk(32'h5ff));
      chk("t5_rst_out", 256'({retire, overflow, desync, stall_1, stall_2}), 256'(0));
      chk("t5_rst_cnt", 256'(pair_cnt), 256'(0));
      step(0, 1, mk(32'h600), 1, mk(32'h600));
      idle(1);
      chk("t5_after_rst", 256'({retire, pair_cnt}), 256'({1'b1, 32'd1}));

      // Sustained push/pop at full across pointer wrap
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 1, mk(32'h700 + i), 0, '0);
      for (int i = 0; i < 2 * DEPTH + 3; i++)
         step(0, 1, mk(32'h703 + i), 1, mk(32'h800 + i));
      for (int i = 0; i < 3; i++) step(0, 0, '0, 1, mk(32'h80b + i));
      idle(3);
      chk("t6_cnt", 256'(pair_cnt), 256'(14));
      chk("t6_no_ovf", 256'(overflow), 256'(0));

      // Randomized traffic; each 200-cycle block restarts from reset with new rates
      p1 = 50; p2 = 50;
      for (int c = 0; c < 3000; c++) begin
         r = (c % 200 == 0) || ($urandom_range(0, 499) == 0);
         if (c % 200 == 0) begin
            p1 = $urandom_range(20, 100);
            p2 = ((c / 200) % 5 == 3) ? 0 : $urandom_range(20, 100);
         end
         v1 = ($urandom_range(0, 99) < p1);
         v2 = ($urandom_range(0, 99) < p2);
         // Mostly honour back-pressure, sometimes ignore it to provoke drops.
         if ($urandom_range(0, 9) != 0) begin
            if (exp_stall(q1.size())) v1 = 0;
            if (exp_stall(q2.size())) v2 = 0;
         end
         step(r, v1, mk($urandom), v2, mk($urandom));
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
